bcd_to_binary_seq: RTL



---
 rtl/bcd_to_binary_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential reverse double-dabble BCD to binary converter
// Define BCD_SIGN_EN to add sign_in and a two's complement BIN_W+1 bit result.
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
`ifdef BCD_SIGN_EN
  input  logic                sign_in,
  output logic [BIN_W:0]      bin_out,
`else
  output logic [BIN_W-1:0]    bin_out,
`endif
  output logic                ready,
  output logic                done,
  output logic                err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
`ifdef BCD_SIGN_EN
  localparam int OUT_W = BIN_W + 1;
`else
  localparam int OUT_W = BIN_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               state_q;
  logic [BCD_W-1:0]     bcd_q;
  logic [BCD_W-1:0]     bcd_d;
  logic [BIN_W-1:0]     bin_q;
  logic [BIN_W-1:0]     bin_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [OUT_W-1:0]     bin_out_q;
  logic [OUT_W-1:0]     result_d;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic                 ready_q;
  logic                 done_q;
  logic                 err_q;
  logic                 in_bad;
`ifdef BCD_SIGN_EN
  logic                 sign_q;
`endif

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then pull any digit >= 8 back by 3.
  always_comb begin
    shifted = {bcd_q, bin_q} >> 1;
    bin_d   = shifted[BIN_W-1:0];
    bcd_d   = shifted[BIN_W +: BCD_W];
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_d[4*i +: 4] >= 4'd8) bcd_d[4*i +: 4] = bcd_d[4*i +: 4] - 4'd3;
    end
  end

`ifdef BCD_SIGN_EN
  assign result_d = sign_q ? -{1'b0, bin_d} : {1'b0, bin_d};
`else
  assign result_d = bin_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef BCD_SIGN_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ready_q <= 1'b0;
            if (in_bad) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              err_q     <= 1'b1;
              bin_out_q <= '0;
            end else begin
              state_q <= S_SHIFT;
              bcd_q   <= bcd_in;
              bin_q   <= '0;
              cnt_q   <= '0;
`ifdef BCD_SIGN_EN
              sign_q  <= sign_in;
`endif
            end
          end
        end
        S_SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // Previous result stays visible until this edge replaces it.
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            err_q     <= 1'b0;
            bin_out_q <= result_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bin_out_q;

endmodule
